apu_irq_ctrl: RTL and testbench

- Interrupt aggregator for the APU processor. It collects level-sensitive requests from APU peripherals: apu_timer irq on source 0, plus audio DMA, the mailbox and the other neighbours on the remaining sources.
- It latches edge-mode sources, applies a per-source enable and forcing, and presents a single registered irq line to the APU core.
- It also presents a registered lowest-index "next pending" vector, so the ISR can dispatch without scanning.
- Software configures it through a zero-wait-state AHB-Lite slave on the APU peripheral bus.

---
 rtl/apu_irq_ctrl.sv | 125 ++++++++++++
 tb/tb_apu_irq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/apu_irq_ctrl.sv
// APU interrupt aggregator: edge/level capture, enable, force, and a registered
// irq line plus lowest-index pending vector, configured over AHB-Lite.
module apu_irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int W_IDX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      ahbls_haddr,
  input  logic [1:0]       ahbls_htrans,
  input  logic             ahbls_hwrite,
  input  logic [2:0]       ahbls_hsize,
  input  logic             ahbls_hready,
  output logic             ahbls_hready_resp,
  input  logic [31:0]      ahbls_hwdata,
  output logic [31:0]      ahbls_hrdata,
  output logic             ahbls_hresp,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq,
  output logic [W_IDX-1:0] irq_num
);

  typedef enum logic [2:0] {
    A_RAW, A_EDGE, A_PEND, A_EN, A_FORCE, A_NEXT, A_RSV6, A_RSV7
  } reg_addr_e;

  logic             dph_vld_q, dph_wr_q, dph_sz_ok_q;
  reg_addr_e        dph_addr_q;
  logic [N_SRC-1:0] edge_q, edge_d, en_q, en_d, force_q, force_d;
  logic [N_SRC-1:0] pend_q, pend_d, src_prev_q;
  logic [N_SRC-1:0] pend_eff, active, wdat, pend_clr;
  logic             irq_q;
  logic [W_IDX-1:0] irq_num_q, irq_num_d;
  logic             wr_en;

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
  assign wdat              = ahbls_hwdata[N_SRC-1:0];
  // A write commits on the edge that ends its data phase, i.e. when hready is high.
  assign wr_en = dph_vld_q & dph_wr_q & dph_sz_ok_q & ahbls_hready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_vld_q   <= 1'b0;
      dph_wr_q    <= 1'b0;
      dph_sz_ok_q <= 1'b0;
      dph_addr_q  <= A_RAW;
    end else if (ahbls_hready) begin
      dph_vld_q   <= ahbls_htrans[1];
      dph_wr_q    <= ahbls_hwrite;
      dph_sz_ok_q <= (ahbls_hsize == 3'd2);
      dph_addr_q  <= reg_addr_e'(ahbls_haddr[4:2]);
    end
  end

  always_comb begin
    edge_d   = edge_q;
    en_d     = en_q;
    force_d  = force_q;
    pend_clr = '0;
    if (wr_en) begin
      unique case (dph_addr_q)
        A_EDGE:  edge_d   = wdat;
        A_PEND:  pend_clr = wdat;
        A_EN:    en_d     = wdat;
        A_FORCE: force_d  = wdat;
        default: ;
      endcase
    end
  end

  // Set beats clear; masking with old and new EDGE drops pend on any mode change.
  assign pend_d   = ((irq_src & ~src_prev_q) | (pend_q & ~pend_clr)) & edge_q & edge_d;
  assign pend_eff = ((edge_q & pend_q) | (~edge_q & irq_src)) | force_q;
  assign active   = pend_eff & en_q;

  always_comb begin
    irq_num_d = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) irq_num_d = W_IDX'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q     <= '0;
      en_q       <= '0;
      force_q    <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      irq_q      <= 1'b0;
      irq_num_q  <= '0;
    end else begin
      edge_q     <= edge_d;
      en_q       <= en_d;
      force_q    <= force_d;
      pend_q     <= pend_d;
      src_prev_q <= irq_src;
      irq_q      <= |active;
      irq_num_q  <= irq_num_d;
    end
  end

  assign irq     = irq_q;
  assign irq_num = irq_num_q;

  always_comb begin
    ahbls_hrdata = '0;
    if (dph_vld_q) begin
      unique case (dph_addr_q)
        A_RAW:   ahbls_hrdata = 32'(irq_src);
        A_EDGE:  ahbls_hrdata = 32'(edge_q);
        A_PEND:  ahbls_hrdata = 32'(pend_eff);
        A_EN:    ahbls_hrdata = 32'(en_q);
        A_FORCE: ahbls_hrdata = 32'(force_q);
        A_NEXT:  ahbls_hrdata = {irq_q, 31'(irq_num_q)};
        default: ahbls_hrdata = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, ahbls_haddr[15:5], ahbls_haddr[1:0], ahbls_htrans[0],
                         ahbls_hwdata[31:N_SRC]};

endmodule

// File: tb/tb_apu_irq_ctrl.sv
// Directed bench for apu_irq_ctrl with hand-computed expectations.
module tb_apu_irq_ctrl;
  localparam int N_SRC = 8;
  localparam int W_IDX = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic             hready;
  logic             hready_resp;
  logic [31:0]      hwdata;
  logic [31:0]      hrdata;
  logic             hresp;
  logic [N_SRC-1:0] irq_src;
  logic             irq;
  logic [W_IDX-1:0] irq_num;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  apu_irq_ctrl #(.N_SRC(N_SRC), .W_IDX(W_IDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_haddr(haddr), .ahbls_htrans(htrans), .ahbls_hwrite(hwrite),
    .ahbls_hsize(hsize), .ahbls_hready(hready), .ahbls_hready_resp(hready_resp),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata), .ahbls_hresp(hresp),
    .irq_src(irq_src), .irq(irq), .irq_num(irq_num)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // All bus tasks start and end just after a rising edge.
  task automatic ahb_wr(input logic [15:0] a, input logic [31:0] d, input logic [2:0] sz);
    haddr = a; htrans = 2'b10; hwrite = 1'b1; hsize = sz;
    tick();
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    tick();
  endtask

  task automatic ahb_rd(input logic [15:0] a, output logic [31:0] d);
    haddr = a; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    tick();
    htrans = 2'b00;
    d = hrdata;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0; hsize = 3'd2;
    hready = 1'b1; hwdata = '0; irq_src = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    for (int i = 0; i < 8; i++) begin
      ahb_rd(16'(i * 4), rd);
      chk($sformatf("rst_rd_%0h", i * 4), rd, 32'h0);
    end
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("hready_resp", {31'h0, hready_resp}, 32'h1);
    chk("hresp", {31'h0, hresp}, 32'h0);

    // edge capture on source 0, then W1C
    ahb_wr(16'h04, 32'h01, 3'd2);
    ahb_wr(16'h0C, 32'h01, 3'd2);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    chk("edge_irq_t1", {31'h0, irq}, 32'h0);
    tick();
    chk("edge_irq_t2", {31'h0, irq}, 32'h1);
    chk("edge_num", 32'(irq_num), 32'h0);
    ahb_rd(16'h08, rd);
    chk("edge_pend", rd, 32'h01);
    ahb_wr(16'h08, 32'h01, 3'd2);
    chk("w1c_irq_same", {31'h0, irq}, 32'h1);
    tick();
    chk("w1c_irq_next", {31'h0, irq}, 32'h0);

    // set wins over simultaneous clear
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    haddr = 16'h08; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h01; irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    ahb_rd(16'h08, rd);
    chk("setwin_pend", rd, 32'h01);
    chk("setwin_irq", {31'h0, irq}, 32'h1);
    ahb_wr(16'h08, 32'h01, 3'd2);
    ahb_wr(16'h04, 32'h00, 3'd2);

    // level mode priority
    ahb_wr(16'h0C, 32'hFF, 3'd2);
    irq_src = 8'h28;
    tick(); tick();
    ahb_rd(16'h14, rd);
    chk("lvl_next", rd, 32'h80000003);
    ahb_rd(16'h00, rd);
    chk("lvl_raw", rd, 32'h28);
    irq_src = 8'h20;
    tick();
    chk("lvl_num5", 32'(irq_num), 32'h5);
    chk("lvl_irq5", {31'h0, irq}, 32'h1);
    irq_src = 8'h00;
    tick();
    chk("lvl_irq_off", {31'h0, irq}, 32'h0);
    ahb_rd(16'h14, rd);
    chk("lvl_next_off", rd, 32'h0);

    // disabled edge source still latches
    ahb_wr(16'h0C, 32'h00, 3'd2);
    ahb_wr(16'h04, 32'h04, 3'd2);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    tick();
    chk("dis_irq", {31'h0, irq}, 32'h0);
    ahb_rd(16'h08, rd);
    chk("dis_pend", rd, 32'h04);
    ahb_wr(16'h0C, 32'h04, 3'd2);
    tick();
    chk("en_irq", {31'h0, irq}, 32'h1);
    chk("en_num", 32'(irq_num), 32'h2);
    ahb_wr(16'h04, 32'h00, 3'd2);
    ahb_rd(16'h08, rd);
    chk("edge_off_discard", rd, 32'h0);
    ahb_wr(16'h0C, 32'h00, 3'd2);

    // force, size filter, aliasing, reserved
    ahb_wr(16'h10, 32'h80, 3'd2);
    ahb_wr(16'h0C, 32'h80, 3'd2);
    tick();
    chk("frc_irq", {31'h0, irq}, 32'h1);
    chk("frc_num", 32'(irq_num), 32'h7);
    ahb_rd(16'h08, rd);
    chk("frc_pend", rd, 32'h80);
    ahb_wr(16'h10, 32'h00, 3'd0);
    tick();
    chk("byte_wr_irq", {31'h0, irq}, 32'h1);
    ahb_rd(16'h0030, rd);
    chk("alias_force", rd, 32'h80);
    ahb_wr(16'h18, 32'hFF, 3'd2);
    ahb_rd(16'h18, rd);
    chk("rsv_rd", rd, 32'h0);
    ahb_wr(16'h10, 32'h00, 3'd2);
    tick();
    chk("frc_clr_irq", {31'h0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
